// File: rtl/sdram_cmd_responder.sv
// SDRAM command responder: mode register, per-bank open-row tracking, CAS-latency read / write beat
// strobes with burst wrap, and command-sequence checking. Define SDRAM_RSP_CHECK_EN to drive err/err_code.
module sdram_cmd_responder #(
    parameter int TMRD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  command,
    input  logic [11:0] addr,
    input  logic [1:0]  ba,
    output logic [3:0]  burst_len,
    output logic [1:0]  cas_lat,
    output logic [3:0]  bank_open,
    output logic        busy,
    output logic        rd_valid,
    output logic        wr_en,
    output logic [1:0]  beat_bank,
    output logic [11:0] beat_row,
    output logic [7:0]  beat_col,
    output logic        err,
    output logic [2:0]  err_code
);
    localparam logic [3:0] CMD_NOP = 4'd0, CMD_ACT = 4'd1, CMD_RD = 4'd2, CMD_WR = 4'd3,
                           CMD_PRE = 4'd4, CMD_REF = 4'd5, CMD_MRS = 4'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_LAT, ST_BURST} state_e;

    state_e            state_q, state_d;
    logic [3:0]        bl_q, bl_d;
    logic [1:0]        cl_q, cl_d;
    logic [3:0]        open_q, open_d;
    logic [3:0][11:0]  row_q, row_d;
    logic [2:0]        tmrd_q, tmrd_d;
    logic              is_rd_q, is_rd_d;
    logic [1:0]        lat_q, lat_d;
    logic [2:0]        rem_q, rem_d, idx_q, idx_d;
    logic [3:0]        bbl_q, bbl_d;
    logic [7:0]        start_q, start_d;
    logic [1:0]        pbank_q, pbank_d;
    logic [11:0]       prow_q, prow_d;
    logic              rd_valid_q, rd_valid_d, wr_en_q, wr_en_d;
    logic [1:0]        beat_bank_q, beat_bank_d;
    logic [11:0]       beat_row_q, beat_row_d;
    logic [7:0]        beat_col_q, beat_col_d;

    logic is_rw, defined, mrs_ok, busy_now, illegal, start_rw;
    logic v_tmrd, v_undef, v_open, v_mrs, v_act, v_busy, v_closed;
    logic [3:0] bl_m1, bbl_m1;

    // Column of beat idx: low log2(bl) bits of the start column wrap, upper bits stay fixed.
    function automatic logic [7:0] wrap_col(input logic [7:0] start, input logic [2:0] idx,
                                            input logic [3:0] bl);
        logic [7:0] m;
        m = {4'b0, bl - 4'd1};
        return (start & ~m) | ((start + {5'b0, idx}) & m);
    endfunction

    assign busy     = (state_q != ST_IDLE);
    assign busy_now = busy;
    assign is_rw    = (command == CMD_RD) || (command == CMD_WR);
    assign defined  = (command <= CMD_REF) || (command == CMD_MRS);
    assign mrs_ok   = !addr[2] && (addr[6:5] == 2'b01);

    always_comb begin
        v_tmrd   = (tmrd_q != 3'd0) && (command != CMD_NOP);
        v_undef  = !defined;
        v_open   = ((command == CMD_MRS) || (command == CMD_REF)) && (open_q != 4'd0);
        v_mrs    = (command == CMD_MRS) && !mrs_ok;
        v_act    = (command == CMD_ACT) && open_q[ba];
        v_busy   = is_rw && busy_now;
        v_closed = is_rw && !open_q[ba];
        illegal  = v_tmrd | v_undef | v_open | v_mrs | v_act | v_busy | v_closed;
        start_rw = is_rw && !illegal;
    end

    // Mode register, bank table and tMRD counter.
    always_comb begin
        bl_d   = bl_q;
        cl_d   = cl_q;
        open_d = open_q;
        row_d  = row_q;
        tmrd_d = (tmrd_q != 3'd0) ? tmrd_q - 3'd1 : 3'd0;
        if (!illegal) begin
            case (command)
                CMD_MRS: begin
                    bl_d   = 4'd1 << addr[1:0];
                    cl_d   = addr[4] ? 2'd3 : 2'd2;
                    tmrd_d = TMRD[2:0];
                end
                CMD_ACT: begin
                    open_d[ba] = 1'b1;
                    row_d[ba]  = addr;
                end
                CMD_PRE: begin
                    if (addr[10]) open_d = 4'd0;
                    else          open_d[ba] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bl_m1  = bl_q - 4'd1;
    assign bbl_m1 = bbl_q - 4'd1;

    always_comb begin
        state_d     = state_q;
        is_rd_d     = is_rd_q;
        lat_d       = lat_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        bbl_d       = bbl_q;
        start_d     = start_q;
        pbank_d     = pbank_q;
        prow_d      = prow_q;
        rd_valid_d  = 1'b0;
        wr_en_d     = 1'b0;
        beat_bank_d = beat_bank_q;
        beat_row_d  = beat_row_q;
        beat_col_d  = beat_col_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rw) begin
                    is_rd_d = (command == CMD_RD);
                    bbl_d   = bl_q;
                    start_d = addr[7:0];
                    pbank_d = ba;
                    prow_d  = row_q[ba];
                    if (command == CMD_WR) begin
                        state_d     = ST_BURST;
                        wr_en_d     = 1'b1;
                        beat_bank_d = ba;
                        beat_row_d  = row_q[ba];
                        beat_col_d  = addr[7:0];
                        idx_d       = 3'd1;
                        rem_d       = bl_m1[2:0];
                    end else begin
                        state_d = ST_LAT;
                        lat_d   = cl_q - 2'd1;
                    end
                end
            end
            ST_LAT: begin
                if (lat_q == 2'd1) begin
                    state_d     = ST_BURST;
                    rd_valid_d  = 1'b1;
                    beat_bank_d = pbank_q;
                    beat_row_d  = prow_q;
                    beat_col_d  = start_q;
                    idx_d       = 3'd1;
                    rem_d       = bbl_m1[2:0];
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_BURST: begin
                if (rem_q != 3'd0) begin
                    rd_valid_d = is_rd_q;
                    wr_en_d    = !is_rd_q;
                    beat_col_d = wrap_col(start_q, idx_q, bbl_q);
                    idx_d      = idx_q + 3'd1;
                    rem_d      = rem_q - 3'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bl_q        <= 4'd1;
            cl_q        <= 2'd2;
            open_q      <= 4'd0;
            row_q       <= '0;
            tmrd_q      <= 3'd0;
            is_rd_q     <= 1'b0;
            lat_q       <= 2'd0;
            rem_q       <= 3'd0;
            idx_q       <= 3'd0;
            bbl_q       <= 4'd1;
            start_q     <= 8'd0;
            pbank_q     <= 2'd0;
            prow_q      <= 12'd0;
            rd_valid_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            beat_bank_q <= 2'd0;
            beat_row_q  <= 12'd0;
            beat_col_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            bl_q        <= bl_d;
            cl_q        <= cl_d;
            open_q      <= open_d;
            row_q       <= row_d;
            tmrd_q      <= tmrd_d;
            is_rd_q     <= is_rd_d;
            lat_q       <= lat_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            bbl_q       <= bbl_d;
            start_q     <= start_d;
            pbank_q     <= pbank_d;
            prow_q      <= prow_d;
            rd_valid_q  <= rd_valid_d;
            wr_en_q     <= wr_en_d;
            beat_bank_q <= beat_bank_d;
            beat_row_q  <= beat_row_d;
            beat_col_q  <= beat_col_d;
        end
    end

    assign burst_len = bl_q;
    assign cas_lat   = cl_q;
    assign bank_open = open_q;
    assign rd_valid  = rd_valid_q;
    assign wr_en     = wr_en_q;
    assign beat_bank = beat_bank_q;
    assign beat_row  = beat_row_q;
    assign beat_col  = beat_col_q;

`ifdef SDRAM_RSP_CHECK_EN
    logic       err_q, err_d;
    logic [2:0] err_code_q, err_code_d;

    always_comb begin
        err_d      = illegal;
        err_code_d = 3'd0;
        if      (v_tmrd)   err_code_d = 3'd1;
        else if (v_undef)  err_code_d = 3'd7;
        else if (v_open)   err_code_d = 3'd4;
        else if (v_mrs)    err_code_d = 3'd5;
        else if (v_act)    err_code_d = 3'd2;
        else if (v_busy)   err_code_d = 3'd6;
        else if (v_closed) err_code_d = 3'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
`else
    assign err      = 1'b0;
    assign err_code = 3'd0;
`endif
endmodule
